// File: rtl/shift_sequencer_pkg.sv
// Shared types and helpers for the shift_sequencer block: FSM state encoding
// and the bit-counter width function.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LD    = 2'd1,
    SHIFT = 2'd2,
    PAR   = 2'd3
  } seq_state_e;

  // Bit counter must hold indices 0..SIZE-1.
  function automatic int unsigned cnt_width(input int unsigned size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// Word-source handshake into shift_sequencer: valid/ready with the word and
// its bit-period divider, both captured on the accept edge.
interface shift_sequencer_if #(
  parameter int unsigned SIZE  = 9,
  parameter int unsigned DIV_W = 8
);
  logic             IN_VALID;
  logic             IN_READY;
  logic [SIZE-1:0]  IN_DATA;
  logic [DIV_W-1:0] DIV;

  modport master (output IN_VALID, output IN_DATA, output DIV, input IN_READY);
  modport slave  (input IN_VALID, input IN_DATA, input DIV, output IN_READY);
endinterface

// File: rtl/shift_sequencer_bit_timer.sv
// Bit-period timer: counts 0..div_i while enabled and emits a one-cycle tick
// on the cycle where the count equals div_i, then restarts from zero.
module bit_timer #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick_o = enable_i && !clear_i && (cnt_q == div_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || tick_o) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Upstream pacing controller for a parallel-load shift register: loads each
// accepted word, strobes SHIFT_EN once per bit period and forwards SO on TX_OUT.
// Optional trailing even-parity bit when SHIFT_SEQ_PARITY_EN is defined.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int unsigned SIZE  = 9,
  parameter int unsigned DIV_W = 8
) (
  input  logic                CLK,
  input  logic                RESET_N,
  shift_sequencer_if.slave    in_if,
  output logic                LOAD,
  output logic                SHIFT_EN,
  output logic [SIZE-1:0]     PI,
  input  logic                SO_IN,
  output logic                TX_OUT,
  output logic                TX_ACTIVE,
  output logic                DONE
);

  localparam int unsigned CNT_W = cnt_width(SIZE);

  seq_state_e       state_q;
  logic [DIV_W-1:0] div_q;
  logic [CNT_W-1:0] bit_q;
  logic             load_q;
  logic [SIZE-1:0]  pi_q;
  logic             active_q;
  logic             done_q;
`ifdef SHIFT_SEQ_PARITY_EN
  logic             par_q;
`endif

  logic tick;
  logic accept;
  logic last_bit;

  assign accept   = in_if.IN_VALID && (state_q == IDLE);
  assign last_bit = (bit_q == CNT_W'(SIZE - 1));

  assign in_if.IN_READY = (state_q == IDLE);
  assign LOAD      = load_q;
  assign PI        = pi_q;
  assign TX_ACTIVE = active_q;
  assign DONE      = done_q;
  assign SHIFT_EN  = (state_q == SHIFT) && tick;

  // Timer is held cleared during LD so the first bit period starts at zero.
  bit_timer #(.DIV_W(DIV_W)) u_bit_timer (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .clear_i  (state_q == LD),
    .enable_i ((state_q == SHIFT) || (state_q == PAR)),
    .div_i    (div_q),
    .tick_o   (tick)
  );

  always_comb begin
    TX_OUT = 1'b1;
    case (state_q)
      SHIFT:   TX_OUT = SO_IN;
`ifdef SHIFT_SEQ_PARITY_EN
      PAR:     TX_OUT = par_q;
`endif
      default: TX_OUT = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      load_q   <= 1'b0;
      pi_q     <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
`ifdef SHIFT_SEQ_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      load_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q  <= LD;
            load_q   <= 1'b1;
            pi_q     <= in_if.IN_DATA;
            div_q    <= in_if.DIV;
            active_q <= 1'b1;
            bit_q    <= '0;
`ifdef SHIFT_SEQ_PARITY_EN
            par_q    <= 1'b0;
`endif
          end
        end
        LD: begin
          state_q <= SHIFT;
          bit_q   <= '0;
        end
        SHIFT: begin
          if (tick) begin
            bit_q <= bit_q + CNT_W'(1);
`ifdef SHIFT_SEQ_PARITY_EN
            par_q <= par_q ^ SO_IN;
            if (last_bit) begin
              state_q <= PAR;
            end
`else
            if (last_bit) begin
              state_q  <= IDLE;
              active_q <= 1'b0;
              done_q   <= 1'b1;
            end
`endif
          end
        end
`ifdef SHIFT_SEQ_PARITY_EN
        PAR: begin
          if (tick) begin
            state_q  <= IDLE;
            active_q <= 1'b0;
            done_q   <= 1'b1;
          end
        end
`endif
        default: begin
          state_q  <= IDLE;
          active_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer paired with a behavioural parallel-load
// shift register (SE_2 tied high); parity expectations follow SHIFT_SEQ_PARITY_EN.
module tb_shift_sequencer;

  localparam int SIZE  = 9;
  localparam int DIV_W = 8;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  logic LOAD, SHIFT_EN, SO_IN, TX_OUT, TX_ACTIVE, DONE;
  logic [SIZE-1:0] PI;
  logic [SIZE-1:0] sr = '0;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  shift_sequencer_if #(.SIZE(SIZE), .DIV_W(DIV_W)) bus ();

  shift_sequencer #(.SIZE(SIZE), .DIV_W(DIV_W)) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .in_if     (bus),
    .LOAD      (LOAD),
    .SHIFT_EN  (SHIFT_EN),
    .PI        (PI),
    .SO_IN     (SO_IN),
    .TX_OUT    (TX_OUT),
    .TX_ACTIVE (TX_ACTIVE),
    .DONE      (DONE)
  );

  // Attached shift register: LOAD has priority, shifts MSB-first on SE_1.
  always @(posedge CLK) begin
    if (LOAD) sr <= PI;
    else if (SHIFT_EN) sr <= {sr[SIZE-2:0], 1'b0};
  end
  assign SO_IN = sr[SIZE-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " ready"},  bus.IN_READY, 1);
    check({tag, " tx"},     TX_OUT, 1);
    check({tag, " load"},   LOAD, 0);
    check({tag, " se"},     SHIFT_EN, 0);
    check({tag, " done"},   DONE, 0);
    check({tag, " active"}, TX_ACTIVE, 0);
  endtask

  // Called just after a negedge; cycle k is the k-th clock period after accept.
  task automatic run_frame(input logic [SIZE-1:0] word, input logic [DIV_W-1:0] div,
                           input bit chg_div, input bit hold_next,
                           input logic [SIZE-1:0] next_word);
    int per, data_end, total, idx;
    logic exp_tx, exp_se;
    per      = int'(div) + 1;
    data_end = 1 + SIZE * per;
    total    = data_end + 1;
`ifdef SHIFT_SEQ_PARITY_EN
    total    = total + per;
`endif
    check($sformatf("w%0h ready_pre", word), bus.IN_READY, 1);
    bus.IN_VALID = 1'b1;
    bus.IN_DATA  = word;
    bus.DIV      = div;
    @(posedge CLK);
    #1;
    if (hold_next) bus.IN_DATA = next_word;
    else bus.IN_VALID = 1'b0;
    for (int k = 1; k <= total; k++) begin
      @(negedge CLK);
      exp_tx = 1'b1;
      exp_se = 1'b0;
      if (k >= 2 && k <= data_end) begin
        idx    = (k - 2) / per;
        exp_tx = word[SIZE-1-idx];
        exp_se = (((k - 2) % per) == per - 1);
      end else if (k > data_end && k < total) begin
        exp_tx = ^word;
      end
      check($sformatf("w%0h k=%0d load", word, k),   LOAD, (k == 1));
      check($sformatf("w%0h k=%0d tx", word, k),     TX_OUT, exp_tx);
      check($sformatf("w%0h k=%0d se", word, k),     SHIFT_EN, exp_se);
      check($sformatf("w%0h k=%0d active", word, k), TX_ACTIVE, (k < total));
      check($sformatf("w%0h k=%0d done", word, k),   DONE, (k == total));
      check($sformatf("w%0h k=%0d ready", word, k),  bus.IN_READY, (k == total));
      if (k == 1) check($sformatf("w%0h pi", word), PI, word);
      if (chg_div && k == 5) bus.DIV = '0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [SIZE-1:0] w;
    bus.IN_VALID = 1'b0;
    bus.IN_DATA  = '0;
    bus.DIV      = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;

    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      check_idle($sformatf("idle%0d", i));
      check($sformatf("idle%0d pi", i), PI, 0);
    end

    run_frame(9'h1A5, 8'd0, 1'b0, 1'b0, '0);
    run_frame(9'h0FF, 8'd3, 1'b1, 1'b0, '0);
    run_frame(9'h001, 8'd0, 1'b0, 1'b1, 9'h100);
    run_frame(9'h100, 8'd0, 1'b0, 1'b0, '0);

    // Abort a DIV=2 frame during bit 4 (cycles 14..16).
    w = 9'h155;
    bus.IN_VALID = 1'b1;
    bus.IN_DATA  = w;
    bus.DIV      = 8'd2;
    @(posedge CLK);
    #1 bus.IN_VALID = 1'b0;
    repeat (15) @(negedge CLK);
    check("abort pre active", TX_ACTIVE, 1);
    check("abort pre tx", TX_OUT, w[4]);
    #2 RESET_N = 1'b0;
    #1;
    check_idle("abort async");
    check("abort async pi", PI, 0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check_idle($sformatf("post_abort%0d", i));
    end

    run_frame(9'h0A6, 8'd1, 1'b0, 1'b0, '0);
    run_frame(9'h1A5, 8'd1, 1'b0, 1'b0, '0);
    run_frame(9'h0F0, 8'hFF, 1'b0, 1'b0, '0);

    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check_idle($sformatf("tail%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Upstream controller for the team's parallel-load shift register (LOAD / SE_1 / SE_2 / PI / SO interface).
- Accepts parallel words over a valid/ready handshake and pulses LOAD to load each word into the register.
- Paces the register with one SHIFT_EN pulse per bit period and forwards the serial stream on TX_OUT. An optional parity bit follows the data.
- Sits between a word source (FIFO or CPU register) and the shift register; SHIFT_EN drives SE_1, and SE_2 is tied high by the integrator.

Parameters:
- SIZE, 9, word width; must equal the attached shift register's size.
- DIV_W, 8, width of the bit-period divider input.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- IN_VALID  input  1  source has a word on IN_DATA.
- IN_READY  output  1  sequencer can accept a word; equals (state == IDLE).
- IN_DATA  input  SIZE  word to transmit.
- DIV  input  DIV_W  bit period minus 1, in clocks; sampled at accept.
- LOAD  output  1  to shift register LOAD.
- SHIFT_EN  output  1  to shift register SE_1.
- PI  output  SIZE  to shift register PI; registered copy of the accepted word.
- SO_IN  input  1  from shift register SO (MSB first).
- TX_OUT  output  1  serial line; 1 when idle.
- TX_ACTIVE  output  1  high from the LOAD cycle through the final bit period.
- DONE  output  1  one-cycle pulse after a frame completes.

Behaviour:
- Reset (async assert, sync deassert handled by the integrator):
  - state = IDLE; LOAD = 0, SHIFT_EN = 0, PI = 0, DONE = 0, TX_ACTIVE = 0, TX_OUT = 1.
  - Bit counter, divider counter and parity accumulator cleared.
  - Reset mid-frame aborts the frame immediately. No DONE is issued, and the shift register contents are left as they are.
- Handshake:
  - A transfer occurs on an edge where IN_VALID & IN_READY.
  - IN_DATA and DIV are captured on that edge.
  - IN_VALID while busy is ignored (held off by IN_READY = 0).
- States:
  - IDLE: TX_OUT = 1. On transfer -> LD.
  - LD: exactly one cycle. LOAD = 1, PI = captured word, TX_ACTIVE = 1. Next state SHIFT, with bit count = 0 and divider = 0.
  - SHIFT:
    - TX_OUT = SO_IN (combinational pass-through).
    - The divider counts 0..DIV. In the cycle where divider == DIV, SHIFT_EN = 1, parity ^= SO_IN, bit count increments and the divider clears.
    - After the bit with index SIZE-1: -> PAR if the feature is on, else -> IDLE.
    - SHIFT_EN is asserted for every data bit, including the last one.
  - PAR (feature only): TX_OUT = accumulated parity for DIV+1 cycles; SHIFT_EN = 0; then -> IDLE.
- DONE:
  - Registered pulse, high in the first IDLE cycle after the frame ends.
  - IN_READY is already 1 in that cycle, so back-to-back frames are allowed and DONE may coincide with the next accept.
- Latency:
  - First data bit appears on TX_OUT 2 cycles after the accept edge.
  - Accept edge to DONE = 2 + SIZE*(DIV+1) cycles, plus (DIV+1) with parity.
- DIV = 0 gives one clock per bit, with SHIFT_EN high on every SHIFT cycle. DIV = all-ones is legal; no wrap occurs because the divider width equals DIV_W.
- A change on DIV mid-frame has no effect until the next accept.

Optional Feature:
- Macro: SHIFT_SEQ_PARITY_EN.
- Defined: the PAR state exists. After the data bits, TX_OUT carries even parity (XOR of all SIZE transmitted bits) for one bit period.
- Undefined: the PAR state and parity register are not synthesised. SHIFT -> IDLE directly, and frame length is 2 + SIZE*(DIV+1).

Decomposition:
- Package shift_seq_pkg holds:
  - state encoding localparams (IDLE, LD, SHIFT, PAR);
  - the width function for the bit counter, clog2(SIZE).
- One natural sub-module: bit_timer.
  - Inputs: CLK, RESET_N, clear, enable, DIV value.
  - Output: one-cycle tick when the count equals DIV.
  - The sequencer instantiates it once.

Test Plan:
- Reset then idle, SIZE=9, DIV=0, no IN_VALID:
  - IN_READY=1, TX_OUT=1, LOAD=0, SHIFT_EN=0, DONE=0 indefinitely.
- Single word 9'h1A5, DIV=0, sequencer paired with the shift register:
  - LOAD high 1 cycle after accept; TX_OUT = 1,1,0,1,0,0,1,0,1 on 9 consecutive cycles; 9 SHIFT_EN pulses.
  - DONE exactly 11 cycles after the accept edge.
- Word 9'h0FF, DIV=3:
  - each bit held 4 cycles; SHIFT_EN pulses spaced 4 apart; DONE at 2+36 = 38 cycles.
  - DIV changed to 0 mid-frame: no effect on the current frame.
- Back-to-back: IN_VALID held high with words 9'h001 then 9'h100, DIV=0:
  - second accept occurs in the same cycle as the first DONE; no idle-high gap beyond that cycle.
- Reset asserted during bit 4 of a DIV=2 frame:
  - all outputs take reset values asynchronously; no DONE.
  - After release, a new word transmits correctly.
- With SHIFT_SEQ_PARITY_EN, word 9'h1A5 (five ones), DIV=1:
  - after 18 data cycles, TX_OUT=1 for 2 cycles; DONE at 2+18+2 = 22.
  - Same word without the macro: DONE at 20.
